user_gpio_irq: RTL
==================

USER_GPIO_IRQ -- requirements
Module: user_gpio_irq

Interface
REQ-001 SHALL have parameter GpioCount, default 16, number of GPIO pins monitored.
REQ-002 SHALL have parameter DebounceCycles, default 4, stable cycles required before a debounced pin changes (range 1..255).
REQ-003 SHALL have port clk_i, input, 1, sole clock.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port gpio_in_sync_i, input, GpioCount, already-synchronised GPIO levels from croc_domain.
REQ-006 SHALL have port obi_req_i, input, sbr_obi_req_t, OBI subordinate request from the user-domain demux.
REQ-007 SHALL have port obi_rsp_o, output, sbr_obi_rsp_t, OBI subordinate response.
REQ-008 SHALL have port irq_o, output, 1, level interrupt towards one bit of the interrupts bus.

Function
REQ-009 SHALL register the sampled pin vector each cycle (prev) and detect rise = cur & ~prev and fall = ~cur & prev, where cur is the filtered level (REQ-022) or gpio_in_sync_i.
REQ-010 SHALL set STATUS[i] in the cycle after rise[i]&RISE_EN[i] or fall[i]&FALL_EN[i].
REQ-011 SHALL drive irq_o = |(STATUS & ENABLE), registered, i.e. asserted one cycle after STATUS updates.
REQ-012 SHALL decode word offsets: 0x00 STATUS (RW1C), 0x04 ENABLE (RW), 0x08 RISE_EN (RW), 0x0C FALL_EN (RW), 0x10 LEVEL (RO, current cur); bits above GpioCount read 0, writes ignored.
REQ-013 SHALL assert gnt combinationally equal to req (no back-pressure) and rvalid exactly one cycle after each granted request, with rid equal to the captured aid.
REQ-014 SHALL return rdata registered at grant time; writes return rdata 0.
REQ-015 SHALL honour byte enables on RW registers; a STATUS write clears only bits with be set and wdata 1.
REQ-016 SHALL set err on the response for offsets ≥ 0x14 or writes to LEVEL, with no state change.
REQ-017 SHALL give set priority over W1C when an edge and a clear hit the same STATUS bit in one cycle (bit stays 1).
REQ-018 SHALL keep STATUS set while ENABLE is 0; enabling later raises irq_o one cycle after the ENABLE write lands.
REQ-019 SHALL accept back-to-back requests every cycle, each answered in order one cycle later.

Reset
REQ-020 SHALL, while rst_i is high at a clk_i edge, clear STATUS, ENABLE, RISE_EN, FALL_EN, rvalid, err, rdata, irq_o, and load prev and filter state from gpio_in_sync_i so no edge fires on reset release.
REQ-021 SHALL drop any in-flight response when reset is asserted mid-transaction; rvalid is 0 in the first cycle after reset.

Configuration
REQ-022 SHALL, with USER_GPIO_IRQ_DEBOUNCE_EN defined, filter each pin through a saturating counter: cur[i] changes only after gpio_in_sync_i[i] differs from cur[i] for DebounceCycles consecutive cycles; any agreeing cycle resets the counter.
REQ-023 SHALL, without USER_GPIO_IRQ_DEBOUNCE_EN, use cur = gpio_in_sync_i directly, instantiate no counters, and ignore DebounceCycles.

Structure
REQ-024 SHALL take sbr_obi_req_t/sbr_obi_rsp_t from croc_pkg and define register offset constants (UserGpioIrqStatusOffset ... UserGpioIrqLevelOffset) there.
REQ-025 SHALL place the per-pin filter in one sub-module user_gpio_debounce, generated GpioCount times under the macro.

Verification
REQ-026 Rise detect: RISE_EN=0x1, ENABLE=0x1, pin0 0→1 -> STATUS=0x1 next cycle, irq_o=1 the cycle after; W1C 0x1 -> irq_o=0 two cycles later.
REQ-027 Collision: pin3 falling edge (FALL_EN=0x8) same cycle as W1C 0x8 -> STATUS[3] reads 1.
REQ-028 Bus: read 0x10 with pins=0xA5A5 -> rdata=0xA5A5, rvalid one cycle after gnt; read 0x20 -> err=1, no state change; write LEVEL -> err=1.
REQ-029 Debounce (macro on, DebounceCycles=4): pin1 pulse of 3 cycles -> no STATUS change; held 4 cycles -> STATUS[1]=1.
REQ-030 Reset: rst_i pulsed with pins=0xFFFF and RISE_EN written post-reset -> no STATUS bit set, irq_o=0; reset mid-read -> no rvalid afterwards.

Source files
------------

// File: rtl/croc_pkg.sv
// Shared SoC types: OBI subordinate request/response structs and the
// user_gpio_irq register map.
package croc_pkg;

    localparam int unsigned SbrObiAidWidth = 4;

    typedef struct packed {
        logic [31:0]               addr;
        logic                      we;
        logic [3:0]                be;
        logic [31:0]               wdata;
        logic [SbrObiAidWidth-1:0] aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        sbr_obi_a_chan_t a;
        logic            req;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0]               rdata;
        logic [SbrObiAidWidth-1:0] rid;
        logic                      err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        sbr_obi_r_chan_t r;
    } sbr_obi_rsp_t;

    // The demux hands over a 4 KiB window; only these low address bits decode.
    localparam int unsigned UserGpioIrqOffsetWidth = 12;

    localparam logic [UserGpioIrqOffsetWidth-1:0] UserGpioIrqStatusOffset = 12'h000;
    localparam logic [UserGpioIrqOffsetWidth-1:0] UserGpioIrqEnableOffset = 12'h004;
    localparam logic [UserGpioIrqOffsetWidth-1:0] UserGpioIrqRiseEnOffset = 12'h008;
    localparam logic [UserGpioIrqOffsetWidth-1:0] UserGpioIrqFallEnOffset = 12'h00C;
    localparam logic [UserGpioIrqOffsetWidth-1:0] UserGpioIrqLevelOffset  = 12'h010;
    localparam logic [UserGpioIrqOffsetWidth-1:0] UserGpioIrqEndOffset    = 12'h014;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/user_gpio_debounce.sv
// Per-pin glitch filter: the output level follows the input only after the
// input has disagreed with it for DebounceCycles consecutive cycles.
module user_gpio_debounce #(
    parameter int unsigned DebounceCycles = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o
);

    localparam logic [7:0] LastCnt = 8'(DebounceCycles - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       level_q, level_d;

    always_comb begin
        cnt_d   = 8'd0;
        level_d = level_q;
        if (pin_i != level_q) begin
            if (cnt_q >= LastCnt) begin
                level_d = pin_i;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Reset adopts the live pin level so release produces no spurious edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= 8'd0;
            level_q <= pin_i;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/user_gpio_irq.sv
// GPIO edge-interrupt controller on an OBI subordinate port.
// Define USER_GPIO_IRQ_DEBOUNCE_EN to filter each pin through user_gpio_debounce.
module user_gpio_irq
    import croc_pkg::*;
#(
    parameter int unsigned GpioCount      = 16,
    parameter int unsigned DebounceCycles = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [GpioCount-1:0] gpio_in_sync_i,
    input  sbr_obi_req_t         obi_req_i,
    output sbr_obi_rsp_t         obi_rsp_o,
    output logic                 irq_o
);

    logic [GpioCount-1:0] cur, prev_q, rise, fall, set_bits, clr_bits;
    logic [GpioCount-1:0] status_q, status_d, enable_q, enable_d;
    logic [GpioCount-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [GpioCount-1:0] wmask, wval;
    logic                 irq_q;

    logic                      rvalid_q, err_q, err_d;
    logic [31:0]               rdata_q, rdata_d, wbits;
    logic [SbrObiAidWidth-1:0] rid_q;

    logic [UserGpioIrqOffsetWidth-1:0] off_w;
    logic                              bad, wr, rd;
    logic                              unused_bits;

`ifdef USER_GPIO_IRQ_DEBOUNCE_EN
    for (genvar i = 0; i < GpioCount; i++) begin : g_deb
        user_gpio_debounce #(
            .DebounceCycles(DebounceCycles)
        ) u_deb (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .pin_i  (gpio_in_sync_i[i]),
            .level_o(cur[i])
        );
    end
`else
    assign cur = gpio_in_sync_i;
`endif

    assign rise     = cur & ~prev_q;
    assign fall     = ~cur & prev_q;
    assign set_bits = (rise & rise_en_q) | (fall & fall_en_q);

    assign off_w = {obi_req_i.a.addr[UserGpioIrqOffsetWidth-1:2], 2'b00};
    assign wbits = obi_req_i.a.wdata & be_to_mask(obi_req_i.a.be);
    assign wmask = GpioCount'(be_to_mask(obi_req_i.a.be));
    assign wval  = GpioCount'(wbits);

    assign bad = (off_w >= UserGpioIrqEndOffset) ||
                 (obi_req_i.a.we && off_w == UserGpioIrqLevelOffset);
    assign wr  = obi_req_i.req &  obi_req_i.a.we & ~bad;
    assign rd  = obi_req_i.req & ~obi_req_i.a.we & ~bad;

    assign unused_bits = ^{obi_req_i.a.addr[31:UserGpioIrqOffsetWidth],
                           obi_req_i.a.addr[1:0], wbits};

    always_comb begin
        clr_bits  = '0;
        enable_d  = enable_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        if (wr) begin
            unique case (off_w)
                UserGpioIrqStatusOffset: clr_bits  = wval;
                UserGpioIrqEnableOffset: enable_d  = (enable_q  & ~wmask) | wval;
                UserGpioIrqRiseEnOffset: rise_en_d = (rise_en_q & ~wmask) | wval;
                UserGpioIrqFallEnOffset: fall_en_d = (fall_en_q & ~wmask) | wval;
                default: ;
            endcase
        end
        // A fresh edge beats a same-cycle W1C on the same bit.
        status_d = (status_q & ~clr_bits) | set_bits;
    end

    always_comb begin
        rdata_d = '0;
        err_d   = obi_req_i.req & bad;
        if (rd) begin
            unique case (off_w)
                UserGpioIrqStatusOffset: rdata_d[GpioCount-1:0] = status_q;
                UserGpioIrqEnableOffset: rdata_d[GpioCount-1:0] = enable_q;
                UserGpioIrqRiseEnOffset: rdata_d[GpioCount-1:0] = rise_en_q;
                UserGpioIrqFallEnOffset: rdata_d[GpioCount-1:0] = fall_en_q;
                UserGpioIrqLevelOffset:  rdata_d[GpioCount-1:0] = cur;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q    <= gpio_in_sync_i;
            status_q  <= '0;
            enable_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            irq_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            rid_q     <= '0;
        end else begin
            prev_q    <= cur;
            status_q  <= status_d;
            enable_q  <= enable_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            irq_q     <= |(status_q & enable_q);
            rvalid_q  <= obi_req_i.req;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            if (obi_req_i.req) begin
                rid_q <= obi_req_i.a.aid;
            end
        end
    end

    assign obi_rsp_o.gnt     = obi_req_i.req;
    assign obi_rsp_o.rvalid  = rvalid_q;
    assign obi_rsp_o.r.rdata = rdata_q;
    assign obi_rsp_o.r.rid   = rid_q;
    assign obi_rsp_o.r.err   = err_q;
    assign irq_o             = irq_q;

endmodule
